// File: rtl/lod_scan_sequencer.sv
// Multi-cycle leading-zero counter for wide quire/accumulator words: scans one
// C_W-bit chunk per cycle, MSB chunk first, through a C_W-wide LOD.

module lod_chunk #(
  parameter int W = 64,
  localparam int CW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt,
  output logic          vld
);
  // Ascending scan so the highest set bit wins; cnt=0 means din[W-1] is set.
  always_comb begin
    cnt = '0;
    vld = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt = CW'(W - 1 - i);
        vld = 1'b1;
      end
    end
  end
endmodule

module lod_scan_sequencer #(
  parameter int C_N = 512,
  parameter int C_W = 64,
  localparam int C_CHUNKS = C_N / C_W,
  localparam int C_LZW = $clog2(C_N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [C_N-1:0]   s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [C_LZW-1:0] m_lzc,
  output logic             m_zero,
  output logic             busy
);
  localparam int WB   = $clog2(C_W);
  localparam int IDXW = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(C_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [C_N-1:0]  data_q;
  logic [C_N-1:0]  shifted;
  logic [C_W-1:0]  chunk;
  logic [WB-1:0]   lod_cnt;
  logic            lod_vld;

  // idx*C_W is just idx with WB zero bits appended.
  assign shifted = data_q << {idx, {WB{1'b0}}};
  assign chunk   = shifted[C_N-1 -: C_W];

  lod_chunk #(.W(C_W)) u_lod (
    .din (chunk),
    .cnt (lod_cnt),
    .vld (lod_vld)
  );

  assign s_ready = (state == IDLE) && !flush && !rst;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      m_valid <= 1'b0;
      m_lzc   <= '0;
      m_zero  <= 1'b0;
    end else if (flush) begin
      // Abort drops any in-flight word; the last result fields are kept.
      state   <= IDLE;
      m_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            data_q <= s_data;
            idx    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (lod_vld) begin
            m_lzc   <= C_LZW'({idx, lod_cnt});
            m_zero  <= 1'b0;
            m_valid <= 1'b1;
            state   <= DONE;
          end else if (idx == LAST) begin
            m_lzc   <= C_LZW'(C_N);
            m_zero  <= 1'b1;
            m_valid <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lod_scan_sequencer.sv
// Directed bench for lod_scan_sequencer with a scoreboard of expected
// count / zero flag / latency, pushed at accept and popped at result.

module tb_lod_scan_sequencer;
  localparam int C_N = 512;
  localparam int C_W = 64;
  localparam int C_LZW = 10;

  logic             clk = 1'b0;
  logic             rst, flush, s_valid, s_ready, m_valid, m_ready, m_zero, busy;
  logic [C_N-1:0]   s_data;
  logic [C_LZW-1:0] m_lzc;

  typedef struct {int lzc; int zero; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  lod_scan_sequencer #(.C_N(C_N), .C_W(C_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_lzc(m_lzc), .m_zero(m_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [C_N-1:0] one_at(input int b);
    logic [C_N-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [C_N-1:0] rnd_word();
    logic [C_N-1:0] v;
    for (int i = 0; i < C_N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge; returns 1 ns after the accept edge.
  task automatic send(input logic [C_N-1:0] d, input int lzc, input int zero, input int k);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    chk("s_ready_idle", s_ready, 1);
    sb.push_back('{lzc, zero, k + 1});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = rnd_word();
  endtask

  // Measures edges from accept until m_valid is seen; ends at a negedge with m_valid high.
  task automatic get_result(input string tag);
    int e;
    exp_t x;
    e = 0;
    @(negedge clk);
    chk({tag, "_busy_scan"}, busy, 1);
    while (m_valid !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    x = sb.pop_front();
    chk({tag, "_m_valid"}, m_valid, 1);
    chk({tag, "_latency"}, e + 1, x.lat);
    chk({tag, "_m_lzc"}, m_lzc, x.lzc);
    chk({tag, "_m_zero"}, m_zero, x.zero);
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_hs_m_valid"}, m_valid, 0);
    chk({tag, "_hs_busy"}, busy, 0);
    chk({tag, "_hs_s_ready"}, s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bits[5] = '{63, 64, 257, 384, 448};
    logic seen;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;

    // Reset state
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_lzc", m_lzc, 0);
    chk("rst_m_zero", m_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    @(negedge clk);

    // Top bit: latency 2, busy for two cycles
    send(one_at(511), 0, 0, 1);
    get_result("top");
    chk("top_busy_done", busy, 1);
    handshake("top");

    // Single low bit and all-zero: full scan
    send(one_at(0), 511, 0, 8);
    get_result("low");
    handshake("low");
    send('0, 512, 1, 8);
    get_result("zero");
    handshake("zero");

    // Chunk boundary with 5 cycles of backpressure
    send(one_at(447) | 512'hFF, 64, 0, 2);
    get_result("bp");
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = rnd_word();
      @(negedge clk);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_lzc", m_lzc, 64);
      chk("bp_hold_zero", m_zero, 0);
      chk("bp_hold_s_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    handshake("bp");

    // Flush mid-scan: word discarded, no m_valid
    send(one_at(0), 511, 0, 8);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_s_ready", s_ready, 0);
    chk("flush_busy_before", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);
    chk("flush_s_ready_after", s_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1'b1;
    end
    chk("flush_no_result", seen, 0);

    // Flush with s_valid in IDLE: not accepted
    s_valid = 1'b1;
    s_data  = one_at(10);
    flush   = 1'b1;
    #1;
    chk("flush_idle_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_not_accepted", busy, 0);

    send(one_at(300), 211, 0, 4);
    get_result("b300");
    handshake("b300");

    // Flush together with m_ready in DONE: result dropped, fields held
    send(one_at(200), 311, 0, 5);
    get_result("b200");
    m_ready = 1'b1;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk("flush_done_m_valid", m_valid, 0);
    chk("flush_done_busy", busy, 0);
    chk("flush_done_lzc_held", m_lzc, 311);
    chk("flush_done_zero_held", m_zero, 0);

    // Highest set bit wins over lower bits; s_data scrambled after accept
    foreach (bits[i]) begin
      send(one_at(bits[i]) | one_at(bits[i] / 2), 511 - bits[i], 0, (511 - bits[i]) / C_W + 1);
      get_result("mix");
      handshake("mix");
    end

    // Async reset in DONE
    send(one_at(100), 411, 0, 7);
    get_result("b100");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_lzc", m_lzc, 0);
    @(negedge clk);
    rst = 1'b0;
    send(one_at(511), 0, 0, 1);
    get_result("after_rst");
    handshake("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
